// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared four-to-one mux.
// Each ownership is capped at MAX_HOLD cycles, and one dead cycle with no
// grant separates consecutive owners so the mux output never switches
// while a grant is live.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       grant_nxt;
  logic [1:0]       sel_nxt;
  logic             busy_nxt;
  logic             timeout_nxt;
  logic [1:0]       winner;

  // First requester found when searching upward from the slot after l,
  // wrapping around; l itself is therefore the lowest priority.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic       found;
    found = 1'b0;
    pick  = l + 2'd1;
    for (int k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] w);
    onehot = 4'b0001 << w;
  endfunction

  assign winner = pick(req, last);

  // Next-state and next-output decode; everything holds unless a branch moves it.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    cnt_nxt     = cnt;
    grant_nxt   = grant;
    sel_nxt     = sel;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (|req) begin
          state_nxt = OWN;
          grant_nxt = onehot(winner);
          sel_nxt   = winner;
          busy_nxt  = 1'b1;
          cnt_nxt   = CNT_W'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN: begin
        // Voluntary release takes precedence; otherwise a release here means
        // the owner is still requesting and has reached the hold cap.
        if (!req[sel] || (cnt == CNT_W'(MAX_HOLD))) begin
          state_nxt   = GAP;
          grant_nxt   = 4'b0000;
          busy_nxt    = 1'b0;
          last_nxt    = sel;
          cnt_nxt     = '0;
          timeout_nxt = req[sel];
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and registered outputs; last starts at 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 2'd3;
      cnt     <= '0;
      grant   <= 4'b0000;
      sel     <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      grant   <= grant_nxt;
      sel     <= sel_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAX_HOLD=8.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic et);
    checks++;
    assert (grant === eg) else begin
      failures++;
      $error("FAIL %s grant=%b expected %b", tag, grant, eg);
    end
    checks++;
    assert (sel === es) else begin
      failures++;
      $error("FAIL %s sel=%0d expected %0d", tag, sel, es);
    end
    checks++;
    assert (busy === eb) else begin
      failures++;
      $error("FAIL %s busy=%b expected %b", tag, busy, eb);
    end
    checks++;
    assert (timeout === et) else begin
      failures++;
      $error("FAIL %s timeout=%b expected %b", tag, timeout, et);
    end
    checks++;
    assert ($countones(grant) <= 1) else begin
      failures++;
      $error("FAIL %s_onehot grant=%b expected popcount<=1", tag, grant);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // All requesting: full rotation with hold-cap timeouts.
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int k = 0; k < 8; k++) begin
        step();
        check("rr_own", 4'b0001 << (o % 4), 2'(o % 4), 1'b1, 1'b0);
      end
      step();
      check("rr_gap", 4'b0000, 2'(o % 4), 1'b0, 1'b1);
    end
    req = 4'b0000;
    step();
    check("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Short request from requester 2, voluntary release.
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      check("short_own", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    check("short_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    check("short_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Sole requester 1 for 20 cycles: 8, gap, 8, gap, 2.
    req = 4'b0010;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        step();
        check("sole_own", 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      step();
      check("sole_gap_to", 4'b0000, 2'd1, 1'b0, 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      check("sole_tail", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    check("sole_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    step();
    check("sole_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Owner 2 with 0 and 3 arriving mid-grant: no pre-emption, then 3 before 0.
    req = 4'b0100;
    step();
    check("np_own", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b1101;
    step();
    check("np_hold1", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    check("np_hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b1001;
    step();
    check("np_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    check("np_win3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0001;
    step();
    check("np_gap2", 4'b0000, 2'd3, 1'b0, 1'b0);
    step();
    check("np_win0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    check("np_gap3", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    check("np_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an ownership.
    req = 4'b0010;
    step();
    check("ar_own", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1000;
    #1;
    rst_n = 1'b1;
    step();
    check("ar_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one four_to_one_mux datapath among four requesters.
- Drives the mux select and a one-hot grant back to the requesters.
- Caps each ownership at MAX_HOLD cycles.
- Inserts one break-before-make dead cycle between owners, so the shared output never switches sources while a grant is live.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant (legal range 1..2**CNT_W-1).
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i is requester i; level-sensitive.
- grant  output  4  one-hot grant, registered; all zero when nobody owns the mux.
- sel  output  2  select for four_to_one_mux; index of current/last owner, registered.
- busy  output  1  high while grant is non-zero.
- timeout  output  1  one-cycle pulse when an owner is cut off at MAX_HOLD.

Behaviour:
- Interface decided: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert; sync-free deassert takes effect at the next edge):
  - grant=0, sel=0, busy=0, timeout=0, cnt=0.
  - state=IDLE, last=3, so requester 0 has top priority first.
- Reset mid-grant drops grant immediately. No state is retained.
- States: IDLE, OWN, GAP.
- Winner selection (combinational): first set bit of req, searching (last+1) mod 4, (last+2) mod 4, ... with wrap-around.
- IDLE:
  - If req!=0 at an edge: grant=onehot(winner), sel=winner, busy=1, cnt=1, go to OWN.
  - Latency is 1 cycle from req sampled to grant.
  - If req==0: stay in IDLE; sel holds.
- OWN (owner w): at each edge, in priority order:
  - req[w]==0: release; grant=0, busy=0, last=w, go to GAP.
  - req[w]==1 and cnt==MAX_HOLD: release as above, and timeout=1 for the next cycle only.
  - Otherwise cnt=cnt+1; grant and sel unchanged.
  - Requests from others during OWN are ignored. There is no pre-emption.
- Hold limits:
  - Grant is high for at most MAX_HOLD cycles.
  - With MAX_HOLD=1, grant is exactly 1 cycle per ownership.
- GAP: exactly one cycle with grant=0; sel holds the previous owner.
  - At the exit edge, if req!=0, arbitrate (using the updated last), grant the winner, cnt=1, go to OWN.
  - Otherwise go to IDLE.
  - Minimum spacing between two grants is therefore one dead cycle.
- Pointer behaviour:
  - A timed-out owner rotates to lowest priority like any other.
  - If it is the sole requester, it is re-granted after the single GAP cycle.
- timeout is registered and never asserted in the same cycle as grant to the timed-out owner.
- Invariants:
  - popcount(grant)<=1 at all times.
  - When busy=1, sel equals the index of the set grant bit.
  - busy==(grant!=0).
- Illegal parameter values (MAX_HOLD=0, or MAX_HOLD>=2**CNT_W) are out of scope. The bench must use legal values only.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0, sel=0, busy=0, timeout=0 throughout.
- req=4'b1111 held, MAX_HOLD=8:
  - grants 0001, 0010, 0100, 1000, 0001 in order.
  - Each grant lasts 8 cycles, with timeout=1 in each following GAP cycle.
  - One grant=0 cycle between owners; sel=0,1,2,3,0.
- req=4'b0100 for 3 cycles then 0:
  - grant=0100, sel=2 one cycle after req rises.
  - Grant lasts 3 cycles, then grant=0, timeout=0, state returns to IDLE after GAP.
- Sole requester 1 holds req for 20 cycles, MAX_HOLD=8 -> grant 0010 for 8, gap 1, 8, gap 1, then 2 cycles; timeout pulses twice.
- Owner 2 active, req[0] and req[3] rise mid-grant; owner drops -> after GAP, grant=1000 (3 precedes 0 after last=2), then 0001.
- Assert rst_n=0 asynchronously mid-OWN (between edges) -> grant=0, busy=0, sel=0 immediately. After release with req=4'b1000, grant=1000 one edge later.
